ripemd_final: RTL and testbench

RIPEMD_FINAL -- requirements
Module: ripemd_final

---
 rtl/ripemd_pkg.sv | 52 +++++
 rtl/ripemd_step.sv | 30 +++
 rtl/ripemd_final.sv | 152 +++++++++++++++
 tb/tb_ripemd_final.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ripemd_pkg.sv
// Shared RIPEMD-160 definitions: IV, round constants, word-select and rotate
// tables (one nibble per step), the boolean round functions and FSM states.
package ripemd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0][31:0] IV  = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                      32'hEFCDAB89, 32'h67452301};
  localparam logic [4:0][31:0] K_L = {32'hA953FD4E, 32'h8F1BBCDC, 32'h6ED9EBA1,
                                      32'h5A827999, 32'h00000000};
  localparam logic [4:0][31:0] K_R = {32'h00000000, 32'h7A6D76E9, 32'h6D703EF3,
                                      32'h5C4DD124, 32'h50A28BE6};

  // Step 0 is the leading hex digit of each table; one 64-bit row per round.
  localparam logic [0:79][3:0] R_L = {64'h0123456789ABCDEF, 64'h74D1A6F3C0952EB8,
                                      64'h3AE49F812706DB5C, 64'h19BA08C4D37FE562,
                                      64'h40597C2AE138B6FD};
  localparam logic [0:79][3:0] R_R = {64'h5E7092B4D6F81A3C, 64'h6B370D5AEF8C4912,
                                      64'hF5137E69B8C2A04D, 64'h86413BF05C2D97AE,
                                      64'hCFA4158762DE039B};
  localparam logic [0:79][3:0] S_L = {64'hBEFC5879BDEF6798, 64'h768DB97F7CF9B7DC,
                                      64'hBD67E9DFE8D65C75, 64'hBCEFEF989E56865C,
                                      64'h9F5B68DC5CDEB856};
  localparam logic [0:79][3:0] S_R = {64'h899BDFF5778BEEC6, 64'h9DF7C89B77C76FDB,
                                      64'h97FB866ECD5EDD75, 64'hF58BEE6E69C9C5F8,
                                      64'h85C9C5E68D65FDBB};

  function automatic logic [31:0] f(input logic [2:0] fsel, input logic [31:0] x,
                                    input logic [31:0] y, input logic [31:0] z);
    case (fsel)
      3'd0:    f = x ^ y ^ z;
      3'd1:    f = (x & y) | (~x & z);
      3'd2:    f = (x | ~y) ^ z;
      3'd3:    f = (x & z) | (y & ~z);
      3'd4:    f = x ^ (y | ~z);
      default: f = 32'h00000000;
    endcase
  endfunction

  function automatic logic [31:0] rol(input logic [31:0] x, input logic [3:0] s);
    rol = (x << s) | (x >> (6'd32 - {2'b00, s}));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    bswap = {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/ripemd_step.sv
// One combinational RIPEMD-160 step for a single line (left or right).
module ripemd_step
  import ripemd_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_x,
  input  logic [31:0] i_k,
  input  logic [3:0]  i_s,
  input  logic [2:0]  i_fsel,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e
);

  logic [31:0] w_sum;

  assign w_sum = i_a + f(i_fsel, i_b, i_c, i_d) + i_x + i_k;
  assign o_a   = i_e;
  assign o_b   = rol(w_sum, i_s) + i_e;
  assign o_c   = i_b;
  assign o_d   = rol(i_c, 4'd10);
  assign o_e   = i_d;

endmodule

// File: rtl/ripemd_final.sv
// Iterative single-block RIPEMD-160: both lines advance one step per clock.
// Optional RIPEMD_CHAIN_EN adds i_chain to continue from the previous digest.
module ripemd_final
  import ripemd_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
`ifdef RIPEMD_CHAIN_EN
  input  logic         i_chain,
`endif
  input  logic [511:0] block,
  output logic [159:0] ans,
  output logic         o_valid
);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_step_en;
  logic             w_finish;
  logic [6:0]       r_step;
  logic [511:0]     r_msg;
  logic [4:0][31:0] r_l;
  logic [4:0][31:0] r_r;
  logic [4:0][31:0] w_l;
  logic [4:0][31:0] w_r;
  logic [4:0][31:0] w_start;
  logic [4:0][31:0] w_base;
  logic [4:0][31:0] w_res;
  logic [159:0]     w_digest;
  logic [159:0]     r_ans;
  logic             r_o_valid;
  logic [2:0]       w_round;
  logic [3:0]       w_xl_idx;
  logic [3:0]       w_xr_idx;
  logic [31:0]      w_xl;
  logic [31:0]      w_xr;

  // state register
  always_ff @(posedge clk) begin
    if (rst_n) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_valid) w_next = RUN; else w_next = IDLE;
      RUN:     if (r_step == 7'd79) w_next = DONE; else w_next = RUN;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // datapath strobes decoded from the state
  always_comb begin
    w_load    = 1'b0;
    w_step_en = 1'b0;
    w_finish  = 1'b0;
    case (r_state)
      IDLE:    w_load    = i_valid;
      RUN:     w_step_en = 1'b1;
      DONE:    w_finish  = 1'b1;
      default: w_load    = 1'b0;
    endcase
  end

`ifdef RIPEMD_CHAIN_EN
  logic [4:0][31:0] r_h;
  logic             r_chain;

  assign w_start = i_chain ? r_h : IV;
  assign w_base  = r_chain ? r_h : IV;

  // chaining state survives between hashes; reset restores the IV
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_h     <= IV;
      r_chain <= 1'b0;
    end else begin
      if (w_load)   r_chain <= i_chain;
      if (w_finish) r_h     <= w_res;
    end
  end
`else
  assign w_start = IV;
  assign w_base  = IV;
`endif

  assign w_round  = r_step[6:4];
  assign w_xl_idx = R_L[r_step];
  assign w_xr_idx = R_R[r_step];
  assign w_xl     = r_msg[{w_xl_idx, 5'd0} +: 32];
  assign w_xr     = r_msg[{w_xr_idx, 5'd0} +: 32];

  ripemd_step u_left (
    .i_a(r_l[0]), .i_b(r_l[1]), .i_c(r_l[2]), .i_d(r_l[3]), .i_e(r_l[4]),
    .i_x(w_xl), .i_k(K_L[w_round]), .i_s(S_L[r_step]), .i_fsel(w_round),
    .o_a(w_l[0]), .o_b(w_l[1]), .o_c(w_l[2]), .o_d(w_l[3]), .o_e(w_l[4])
  );

  ripemd_step u_right (
    .i_a(r_r[0]), .i_b(r_r[1]), .i_c(r_r[2]), .i_d(r_r[3]), .i_e(r_r[4]),
    .i_x(w_xr), .i_k(K_R[w_round]), .i_s(S_R[r_step]), .i_fsel(3'd4 - w_round),
    .o_a(w_r[0]), .o_b(w_r[1]), .o_c(w_r[2]), .o_d(w_r[3]), .o_e(w_r[4])
  );

  // final permutation of the two lines plus the starting state
  assign w_res[0] = w_base[1] + r_l[2] + r_r[3];
  assign w_res[1] = w_base[2] + r_l[3] + r_r[4];
  assign w_res[2] = w_base[3] + r_l[4] + r_r[0];
  assign w_res[3] = w_base[4] + r_l[0] + r_r[1];
  assign w_res[4] = w_base[0] + r_l[1] + r_r[2];
  assign w_digest = {bswap(w_res[0]), bswap(w_res[1]), bswap(w_res[2]),
                     bswap(w_res[3]), bswap(w_res[4])};

  // message latch, step counter and working variables of both lines
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_msg  <= '0;
      r_step <= 7'd0;
      r_l    <= '0;
      r_r    <= '0;
    end else if (w_load) begin
      r_msg  <= block;
      r_step <= 7'd0;
      r_l    <= w_start;
      r_r    <= w_start;
    end else if (w_step_en) begin
      r_l    <= w_l;
      r_r    <= w_r;
      r_step <= (r_step == 7'd79) ? 7'd0 : r_step + 7'd1;
    end
  end

  // digest register and one-cycle completion pulse
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_ans     <= '0;
      r_o_valid <= 1'b0;
    end else begin
      r_o_valid <= w_finish;
      if (w_finish) r_ans <= w_digest;
    end
  end

  assign ans     = r_ans;
  assign o_valid = r_o_valid;

endmodule

// File: tb/tb_ripemd_final.sv
// Directed/random bench for ripemd_final with an algorithmic RIPEMD-160 model
// (tables derived from the rho/pi permutations and the per-round shift table).
module tb_ripemd_final;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
`ifdef RIPEMD_CHAIN_EN
  logic         i_chain;
`endif
  logic [511:0] block;
  logic [159:0] ans;
  logic         o_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ripemd_final dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
`ifdef RIPEMD_CHAIN_EN
    .i_chain(i_chain),
`endif
    .block(block), .ans(ans), .o_valid(o_valid)
  );

  int rho [16] = '{7, 4, 13, 1, 10, 6, 15, 3, 12, 0, 9, 5, 2, 14, 11, 8};
  int shift_tab [5][16] = '{
    '{11, 14, 15, 12, 5, 8, 7, 9, 11, 13, 14, 15, 6, 7, 9, 8},
    '{12, 13, 11, 15, 6, 9, 9, 7, 12, 15, 11, 13, 7, 8, 7, 7},
    '{13, 15, 14, 11, 7, 7, 6, 8, 13, 14, 13, 12, 5, 5, 6, 9},
    '{14, 11, 12, 14, 8, 6, 5, 5, 15, 12, 15, 14, 9, 9, 8, 6},
    '{15, 12, 13, 13, 9, 5, 8, 6, 14, 11, 12, 11, 8, 6, 5, 5}};
  logic [31:0] kl [5] = '{32'h00000000, 32'h5A827999, 32'h6ED9EBA1, 32'h8F1BBCDC, 32'hA953FD4E};
  logic [31:0] kr [5] = '{32'h50A28BE6, 32'h5C4DD124, 32'h6D703EF3, 32'h7A6D76E9, 32'h00000000};

  function automatic logic [4:0][31:0] iv_words();
    logic [4:0][31:0] h;
    h[0] = 32'h67452301; h[1] = 32'hEFCDAB89; h[2] = 32'h98BADCFE;
    h[3] = 32'h10325476; h[4] = 32'hC3D2E1F0;
    return h;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] fb(input int rnd, input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    case (rnd)
      0:       return x ^ y ^ z;
      1:       return (x & y) | (~x & z);
      2:       return (x | ~y) ^ z;
      3:       return (x & z) | (y & ~z);
      default: return x ^ (y | ~z);
    endcase
  endfunction

  function automatic logic [4:0][31:0] compress(input logic [511:0] blk, input logic [4:0][31:0] h);
    logic [31:0] x [16];
    logic [31:0] al, bl, cl, dl, el, ar, br, cr, dr, er, t;
    logic [4:0][31:0] o;
    int rnd, wl, wr;
    for (int i = 0; i < 16; i++) x[i] = blk[32*i +: 32];
    {el, dl, cl, bl, al} = h;
    {er, dr, cr, br, ar} = h;
    for (int j = 0; j < 80; j++) begin
      rnd = j / 16;
      wl  = j % 16;
      wr  = (9 * wl + 5) % 16;
      for (int k = 0; k < rnd; k++) begin
        wl = rho[wl];
        wr = rho[wr];
      end
      t  = rotl(al + fb(rnd, bl, cl, dl) + x[wl] + kl[rnd], shift_tab[rnd][wl]) + el;
      al = el; el = dl; dl = rotl(cl, 10); cl = bl; bl = t;
      t  = rotl(ar + fb(4 - rnd, br, cr, dr) + x[wr] + kr[rnd], shift_tab[rnd][wr]) + er;
      ar = er; er = dr; dr = rotl(cr, 10); cr = br; br = t;
    end
    o[0] = h[1] + cl + dr;
    o[1] = h[2] + dl + er;
    o[2] = h[3] + el + ar;
    o[3] = h[4] + al + br;
    o[4] = h[0] + bl + cr;
    return o;
  endfunction

  // digest bytes in hex-string order: h0 low byte first
  function automatic logic [159:0] to_ans(input logic [4:0][31:0] h);
    logic [159:0] r;
    for (int i = 0; i < 5; i++)
      for (int b = 0; b < 4; b++)
        r[159 - 8*(4*i + b) -: 8] = h[i][8*b +: 8];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
    return b;
  endfunction

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [511:0] blk);
    @(negedge clk);
    block   = blk;
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [159:0] exp);
    int lat;
    int moved;
    logic [159:0] a0;
    a0 = ans; lat = 0; moved = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!o_valid && ans !== a0) moved = 1;
    end while (!o_valid && lat < 200);
    check_int({tag, "_latency"}, lat, 81);
    check({tag, "_ans"}, ans, exp);
    check_int({tag, "_ans_held_during_run"}, moved, 0);
    @(posedge clk);
    #1;
    check({tag, "_pulse_width"}, {159'd0, o_valid}, 160'd0);
  endtask

  logic [511:0]     b_empty, b_abc, b_yang, b_a, b_c, b_b;
  logic [4:0][31:0] h_tmp;
  logic [159:0]     e_abc, e_tmp, a_seen;
  int n, cnt, lat, p1, p2, bad;

  initial begin
    rst_n = 1'b1; i_valid = 1'b0; block = '0;
`ifdef RIPEMD_CHAIN_EN
    i_chain = 1'b0;
`endif
    b_empty = '0; b_empty[31:0] = 32'h00000080;
    b_abc   = '0; b_abc[31:0] = 32'h80636261; b_abc[32*14 +: 32] = 32'h00000018;
    b_yang  = '0; b_yang[31:0] = 32'h7473614D; b_yang[63:32] = 32'h59207265;
    b_yang[95:64] = 32'h80676E61; b_yang[32*14 +: 32] = 32'h00000058;
    e_abc   = 160'h8eb208f7e05d987a9b044a8e98c6b087f15a0bfc;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    check("reset_o_valid", {159'd0, o_valid}, 160'd0);
    check("reset_ans", ans, 160'd0);

    start(b_empty);
    wait_done("vec_empty", 160'h9c1185a5c5e9fc54612808977ee8f548b2258d31);
    start(b_abc);
    wait_done("vec_abc", e_abc);
    start(b_yang);
    wait_done("vec_master_yang", 160'hfedcd200dc0f8b4c51ad7ae734282ff2008bbb12);

    for (int i = 0; i < 3; i++) begin
      b_a = rand_block();
      start(b_a);
      wait_done("random", to_ans(compress(b_a, iv_words())));
    end

    // new request and block change while busy must be ignored
    b_a = rand_block(); b_c = rand_block();
    e_tmp = to_ans(compress(b_a, iv_words()));
    start(b_a);
    cnt = 0; lat = 0; n = 0; a_seen = '0;
    while (n < 250) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 10) begin block = b_c; i_valid = 1'b1; end
      if (n == 12) i_valid = 1'b0;
      if (o_valid) begin
        cnt++;
        if (lat == 0) begin lat = n; a_seen = ans; end
      end
    end
    check_int("busy_pulse_count", cnt, 1);
    check_int("busy_latency", lat, 81);
    check("busy_ans", a_seen, e_tmp);

    // i_valid held high: back-to-back hashes every 82 cycles
    b_b = rand_block();
    e_tmp = to_ans(compress(b_b, iv_words()));
    @(negedge clk);
    block = b_b; i_valid = 1'b1;
    @(posedge clk);
    n = 0; p1 = 0; p2 = 0; bad = 0;
    while (n < 400 && p2 == 0) begin
      @(posedge clk);
      #1;
      n++;
      if (o_valid) begin
        if (p1 == 0) p1 = n; else p2 = n;
      end else if (p1 != 0 && ans !== e_tmp) bad++;
    end
    i_valid = 1'b0;
    check_int("hold_first_pulse", p1, 81);
    check_int("hold_second_pulse", p2, 163);
    check_int("hold_ans_unstable_cycles", bad, 0);
    check("hold_ans", ans, e_tmp);
    repeat (3) @(posedge clk);

    // reset in the middle of a hash aborts it
    start(b_abc);
    repeat (40) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    cnt = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) cnt++;
    end
    check_int("abort_no_pulse", cnt, 0);
    check("abort_ans_cleared", ans, 160'd0);
    start(b_abc);
    wait_done("after_abort_abc", e_abc);

`ifdef RIPEMD_CHAIN_EN
    // two-block message of 56 'a' bytes
    b_a = '0;
    for (int i = 0; i < 14; i++) b_a[32*i +: 32] = 32'h61616161;
    b_a[32*14 +: 32] = 32'h00000080;
    b_b = '0; b_b[32*14 +: 32] = 32'h000001C0;
    h_tmp = compress(b_a, iv_words());
    i_chain = 1'b0;
    start(b_a);
    wait_done("chain_block1", to_ans(h_tmp));
    i_chain = 1'b1;
    start(b_b);
    wait_done("chain_block2", 160'he72334b46c83cc70bef979e15453706c95b888be);
    i_chain = 1'b0;
    start(b_abc);
    wait_done("chain_off_abc", e_abc);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
